// File: rtl/neo_memcard_pkg.sv
// neo_memcard_pkg: shared save-FSM state type and default card geometry
package neo_memcard_pkg;
  typedef enum logic [1:0] {S_IDLE, S_DIRTY, S_REQ, S_SAVING} save_state_t;
  localparam int DEF_ADDR_W = 11;
  localparam int DEF_IDLE_CYCLES = 2400000;
endpackage

// File: rtl/neo_memcard_ram.sv
// neo_memcard_ram: true dual-port byte RAM, port A read/write, port B read-only
module neo_memcard_ram #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [7:0]        din_a,
  output logic [7:0]        dout_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [7:0]        dout_b
);
  logic [7:0] mem [2**ADDR_W];
  // storage array is never reset so card contents survive a reset
  always_ff @(posedge clk)
    if (we_a) mem[addr_a] <= din_a;
  // registered read-first outputs, parked at 8'hFF under reset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dout_a <= 8'hFF;
      dout_b <= 8'hFF;
    end else begin
      dout_a <= mem[addr_a];
      dout_b <= mem[addr_b];
    end
endmodule

// File: rtl/neo_memcard.sv
// neo_memcard: 68K memory card with host image load/dump and idle-timed save requests
module neo_memcard import neo_memcard_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] CDA,
  input  logic [15:0]       CDD_IN,
  output logic [15:0]       CDD_OUT,
  output logic              CDD_OE,
  input  logic              nCE,
  input  logic              nOE,
  input  logic              nWE,
  input  logic              CARD_PRESENT,
  input  logic              CARD_WP,
  output logic              nCD1,
  output logic              nCD2,
  input  logic              LOAD_WR,
  input  logic [ADDR_W-1:0] LOAD_ADDR,
  input  logic [7:0]        LOAD_DATA,
  output logic              SAVE_REQ,
  input  logic              SAVE_ACK,
  input  logic              SAVE_DONE,
  input  logic [ADDR_W-1:0] DUMP_ADDR,
  output logic [7:0]        DUMP_DATA
);
  localparam int CNT_W = $clog2(IDLE_CYCLES);
  logic              nwe_q, present_q, pend, commit, pending, pending_n, unused_hi;
  logic [ADDR_W-1:0] pend_addr;
  logic [7:0]        pend_data, dout_a;
  logic [CNT_W-1:0]  cnt, cnt_n;
  save_state_t       state, state_n;
  assign unused_hi = &CDD_IN[15:8];
  assign commit = nwe_q & ~nWE & ~nCE & CARD_PRESENT & ~CARD_WP & ~LOAD_WR;
  assign CDD_OE = ~nCE & ~nOE & nWE & CARD_PRESENT;
  assign nCD1 = ~CARD_PRESENT;
  assign nCD2 = ~CARD_PRESENT;
  assign CDD_OUT = {8'hFF, present_q ? dout_a : 8'hFF};
  assign SAVE_REQ = state == S_REQ;
  // capture nWE edge history and stage the winning write (load beats 68K) for the next edge
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      nwe_q     <= 1'b1;
      present_q <= 1'b0;
      pend      <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
    end else begin
      nwe_q     <= nWE;
      present_q <= CARD_PRESENT;
      pend      <= LOAD_WR | commit;
      pend_addr <= LOAD_WR ? LOAD_ADDR : CDA;
      pend_data <= LOAD_WR ? LOAD_DATA : CDD_IN[7:0];
    end
  neo_memcard_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk(CLK), .rst(RESET), .we_a(pend), .addr_a(pend ? pend_addr : CDA), .din_a(pend_data),
    .dout_a(dout_a), .addr_b(DUMP_ADDR), .dout_b(DUMP_DATA)
  );
  // save FSM state, idle counter and write-during-save flag
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state   <= S_IDLE;
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pending <= pending_n;
    end
  // save FSM transitions; the counter free-runs and saturates, cleared whenever a quiet period restarts
  always_comb begin
    state_n = state;
    cnt_n = cnt + CNT_W'(cnt != '1);
    pending_n = pending;
    case (state)
      S_IDLE:
        if (commit) begin
          state_n = S_DIRTY;
          cnt_n = '0;
        end
      S_DIRTY:
        if (!CARD_PRESENT) state_n = S_IDLE;
        else if (commit) cnt_n = '0;
        else if (cnt == CNT_W'(IDLE_CYCLES - 1)) state_n = S_REQ;
      S_REQ:
        if (!CARD_PRESENT) state_n = S_IDLE;
        else if (SAVE_ACK) state_n = S_SAVING;
      S_SAVING: begin
        pending_n = pending | commit;
        if (SAVE_DONE) begin
          state_n = pending_n ? S_DIRTY : S_IDLE;
          cnt_n = '0;
          pending_n = 1'b0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_neo_memcard.sv
// tb_neo_memcard: scoreboard bench with a cycle-level reference model of the card
module tb_neo_memcard;
  localparam int AW = 11;
  localparam int N = 100;
  typedef struct {
    int          tgt;
    bit          comb;
    logic [15:0] cdd;
    bit          ccdd;
    logic [7:0]  dump;
    bit          cdump;
    bit          sreq;
    bit          oe;
    bit          ncd;
  } item_t;
  logic CLK = 0, RESET = 1;
  logic [AW-1:0] CDA = '0, LOAD_ADDR = '0, DUMP_ADDR = '0;
  logic [15:0] CDD_IN = '0, CDD_OUT;
  logic CDD_OE, nCD1, nCD2, SAVE_REQ;
  logic nCE = 1, nOE = 1, nWE = 1, CARD_PRESENT = 0, CARD_WP = 0;
  logic LOAD_WR = 0, SAVE_ACK = 0, SAVE_DONE = 0;
  logic [7:0] LOAD_DATA = '0, DUMP_DATA;
  int cyc = 0, checks = 0, errors = 0;
  item_t q[$];
  logic [7:0] mem [2**AW];
  bit known [2**AW];
  bit m_nwe_prev = 1, m_pend = 0, m_req = 0, m_saving = 0, m_pending = 0;
  int m_paddr = 0, m_since = -1;
  logic [7:0] m_pdata = '0;

  neo_memcard #(.ADDR_W(AW), .IDLE_CYCLES(N)) dut (
    .CLK(CLK), .RESET(RESET), .CDA(CDA), .CDD_IN(CDD_IN), .CDD_OUT(CDD_OUT), .CDD_OE(CDD_OE),
    .nCE(nCE), .nOE(nOE), .nWE(nWE), .CARD_PRESENT(CARD_PRESENT), .CARD_WP(CARD_WP),
    .nCD1(nCD1), .nCD2(nCD2), .LOAD_WR(LOAD_WR), .LOAD_ADDR(LOAD_ADDR), .LOAD_DATA(LOAD_DATA),
    .SAVE_REQ(SAVE_REQ), .SAVE_ACK(SAVE_ACK), .SAVE_DONE(SAVE_DONE),
    .DUMP_ADDR(DUMP_ADDR), .DUMP_DATA(DUMP_DATA)
  );

  initial forever #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // expected outputs after the coming edge, from the card's rules applied to the current inputs
  task automatic model(output item_t r);
    bit commit;
    int t;
    t = cyc + 1;
    r = '{default: 0};
    if (RESET) begin
      m_nwe_prev = 1; m_pend = 0; m_req = 0; m_saving = 0; m_pending = 0; m_since = -1;
      r.cdd = 16'hFFFF; r.ccdd = 1; r.dump = 8'hFF; r.cdump = 1; r.sreq = 0;
      return;
    end
    commit = m_nwe_prev && !nWE && !nCE && CARD_PRESENT && !CARD_WP && !LOAD_WR;
    r.ccdd = !m_pend && (!CARD_PRESENT || known[CDA]);
    r.cdd = CARD_PRESENT ? {8'hFF, mem[CDA]} : 16'hFFFF;
    r.cdump = known[DUMP_ADDR] && !(m_pend && m_paddr == int'(DUMP_ADDR));
    r.dump = mem[DUMP_ADDR];
    if (m_pend) begin
      mem[m_paddr] = m_pdata;
      known[m_paddr] = 1;
    end
    m_pend = LOAD_WR || commit;
    m_paddr = LOAD_WR ? int'(LOAD_ADDR) : int'(CDA);
    m_pdata = LOAD_WR ? LOAD_DATA : CDD_IN[7:0];
    m_nwe_prev = nWE;
    if (m_saving) begin
      if (commit) m_pending = 1;
      if (SAVE_DONE) begin
        m_saving = 0;
        m_since = m_pending ? t : -1;
        m_pending = 0;
      end
    end else if (m_req) begin
      if (!CARD_PRESENT) m_req = 0;
      else if (SAVE_ACK) begin m_req = 0; m_saving = 1; end
    end else if (m_since >= 0) begin
      if (!CARD_PRESENT) m_since = -1;
      else if (commit) m_since = t;
      else if (t - m_since == N) begin m_req = 1; m_since = -1; end
    end else if (commit) m_since = t;
    r.sreq = m_req;
  endtask

  task automatic step();
    item_t c, r;
    c = '{default: 0};
    c.tgt = cyc; c.comb = 1;
    c.oe = !nCE && !nOE && nWE && CARD_PRESENT;
    c.ncd = !CARD_PRESENT;
    q.push_back(c);
    model(r);
    r.tgt = cyc + 1;
    q.push_back(r);
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    RESET = 1;
    q.delete();
    step();
    RESET = 0;
  endtask

  task automatic idle(input int n);
    nWE = 1; nCE = 1; LOAD_WR = 0; SAVE_ACK = 0; SAVE_DONE = 0;
    for (int i = 0; i < n; i++) begin
      DUMP_ADDR = AW'($urandom);
      step();
    end
  endtask

  task automatic write68k(input logic [AW-1:0] a, input logic [7:0] d, input int hold);
    nCE = 0; CDA = a; CDD_IN = {8'($urandom), d}; nWE = 0;
    for (int i = 0; i < hold; i++) step();
    nWE = 1; nCE = 1;
    step();
  endtask

  task automatic read68k(input logic [AW-1:0] a);
    nCE = 0; nOE = 0; CDA = a; DUMP_ADDR = a;
    step(); step();
    nCE = 1; nOE = 1;
  endtask

  // monitor: pops every expectation that falls due this cycle and compares it with the DUT
  initial forever begin
    item_t it;
    @(negedge CLK);
    while (q.size() > 0 && q[0].tgt <= cyc) begin
      it = q.pop_front();
      if (it.comb) begin
        chk("cdd_oe", 16'(CDD_OE), 16'(it.oe));
        chk("ncd1", 16'(nCD1), 16'(it.ncd));
        chk("ncd2", 16'(nCD2), 16'(it.ncd));
      end else begin
        if (it.ccdd) chk("cdd_out", CDD_OUT, it.cdd);
        if (it.cdump) chk("dump_data", 16'(DUMP_DATA), 16'(it.dump));
        chk("save_req", 16'(SAVE_REQ), 16'(it.sreq));
      end
    end
  end

  initial begin
    @(posedge CLK); #1;
    step(); step();
    RESET = 0;
    for (int a = 0; a < 2**AW; a++) begin
      LOAD_WR = 1; LOAD_ADDR = AW'(a); LOAD_DATA = 8'($urandom); DUMP_ADDR = AW'($urandom);
      step();
    end
    LOAD_WR = 0; CARD_PRESENT = 1;
    idle(2);
    write68k(11'h010, 8'h5A, 3);
    read68k(11'h010);
    idle(45);
    write68k(11'h011, 8'h77, 1);
    idle(110);
    nCE = 0; nOE = 0; CARD_PRESENT = 0;
    step(); step();
    nCE = 1; nOE = 1; CARD_PRESENT = 1;
    idle(5);
    write68k(11'h012, 8'h12, 2);
    idle(105);
    SAVE_ACK = 1; step(); SAVE_ACK = 0;
    idle(3);
    write68k(11'h013, 8'h13, 1);
    SAVE_DONE = 1; step(); SAVE_DONE = 0;
    idle(105);
    SAVE_ACK = 1; step(); SAVE_ACK = 0;
    SAVE_DONE = 1; step(); SAVE_DONE = 0;
    idle(5);
    CARD_WP = 1;
    write68k(11'h020, 8'h33, 2);
    CARD_WP = 0;
    read68k(11'h020);
    idle(110);
    LOAD_WR = 1; LOAD_ADDR = 11'h030; LOAD_DATA = 8'hC3;
    nCE = 0; CDA = 11'h030; CDD_IN = 16'h0011; nWE = 0;
    step();
    LOAD_WR = 0; nWE = 1; nCE = 1;
    step();
    read68k(11'h030);
    idle(110);
    write68k(11'h040, 8'h40, 1);
    idle(105);
    SAVE_ACK = 1; step(); SAVE_ACK = 0;
    idle(2);
    do_reset();
    idle(110);
    read68k(11'h040);
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 30; i++) begin
        nCE = ($urandom % 2 == 0); nOE = ($urandom % 2 == 0); nWE = ($urandom % 3 != 0);
        CDA = AW'($urandom); CDD_IN = 16'($urandom);
        CARD_WP = ($urandom % 8 == 0); CARD_PRESENT = ($urandom % 32 != 0);
        LOAD_WR = ($urandom % 12 == 0); LOAD_ADDR = AW'($urandom); LOAD_DATA = 8'($urandom);
        SAVE_ACK = ($urandom % 4 == 0); SAVE_DONE = ($urandom % 6 == 0);
        DUMP_ADDR = AW'($urandom);
        step();
      end
      LOAD_WR = 0; nWE = 1; CARD_PRESENT = 1; CARD_WP = 0;
      for (int i = 0; i < 130; i++) begin
        nCE = ($urandom % 2 == 0); nOE = ($urandom % 2 == 0); CDA = AW'($urandom);
        SAVE_ACK = ($urandom % 8 == 0); SAVE_DONE = ($urandom % 8 == 0);
        DUMP_ADDR = AW'($urandom);
        step();
      end
      if (r == 10) do_reset();
    end
    idle(2);
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge CLK);
    #1;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
